memrequest_responder: RTL and testbench



---
 rtl/memreq_pkg.sv | 18 +
 rtl/memrequest_responder_if.sv | 23 ++
 rtl/memreq_queue.sv | 54 +++++
 rtl/memrequest_responder.sv | 136 +++++++++++++
 tb/tb_memrequest_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memreq_pkg.sv
// rtl/memreq_pkg.sv - shared widths, request record and FSM states for the memrequest responder
package memreq_pkg;

  localparam int MEMREQ_ADDR_W = 24;
  localparam int MEMREQ_DATA_W = 128;

  typedef struct packed {
    logic [MEMREQ_ADDR_W-1:0] addr;
    logic                     we;
    logic [MEMREQ_DATA_W-1:0] wdata;
  } memreq_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } resp_state_t;

endpackage

// File: rtl/memrequest_responder_if.sv
// rtl/memrequest_responder_if.sv - memrequest bus between an initiator and the responder
interface memrequest_responder_if #(
  parameter int ADDR_W = memreq_pkg::MEMREQ_ADDR_W,
  parameter int DATA_W = memreq_pkg::MEMREQ_DATA_W
);
  logic [ADDR_W-1:0] memrequest_addr;
  logic              memrequest_en;
  logic              memrequest_write_enable;
  logic [DATA_W-1:0] memrequest_write_data;
  logic              memrequest_busy;
  logic              memrequest_complete;
  logic [DATA_W-1:0] memrequest_resp_data;

  modport master (
    output memrequest_addr, memrequest_en, memrequest_write_enable, memrequest_write_data,
    input  memrequest_busy, memrequest_complete, memrequest_resp_data
  );

  modport slave (
    input  memrequest_addr, memrequest_en, memrequest_write_enable, memrequest_write_data,
    output memrequest_busy, memrequest_complete, memrequest_resp_data
  );
endinterface

// File: rtl/memreq_queue.sv
// rtl/memreq_queue.sv - in-order request FIFO holding accepted memreq_t entries
module memreq_queue
  import memreq_pkg::*;
#(
  parameter int QDEPTH = 8,
  parameter int CNT_W  = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  memreq_t          din,
  input  logic             pop,
  output memreq_t          dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(QDEPTH);

  memreq_t           storage [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = storage[rd_ptr];

  // Entry storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memrequest_responder.sv
// rtl/memrequest_responder.sv - BRAM-backed memrequest responder with calibration hold and fixed read latency
// Optional busy injection: MEMREQ_BUSY_INJECT_EN
module memrequest_responder
  import memreq_pkg::*;
#(
  parameter int ADDR_W       = MEMREQ_ADDR_W,
  parameter int DATA_W       = MEMREQ_DATA_W,
  parameter int DEPTH        = 115200,
  parameter int QDEPTH       = 8,
  parameter int READ_LATENCY = 4,
  parameter int INIT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  memrequest_responder_if.slave mem,
  output logic                  init_done,
  output logic [15:0]           oor_count
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  resp_state_t       state_q;
  resp_state_t       state_d;
  logic [31:0]       init_cnt;
  logic              busy;
  logic              inject;

  logic              push;
  logic              pop;
  memreq_t           q_din;
  memreq_t           q_dout;
  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              q_empty;

  logic              in_range;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_raw;

  logic [READ_LATENCY-1:0] pv;
  logic                    p0_keep;
  logic [DATA_W-1:0]       pd [1:READ_LATENCY-1];
  logic                    complete_q;
  logic [DATA_W-1:0]       resp_q;

`ifdef MEMREQ_BUSY_INJECT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign inject = (state_q == RUN) && (lfsr[2:0] == 3'd0);
`else
  assign inject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Busy depends only on registered state so the initiator never sees a loop through en.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    case (state_q)
      INIT: if (init_cnt == 32'(INIT_CYCLES)) state_d = RUN;
      RUN:  busy = inject || (q_count >= CNT_W'(QDEPTH - 1));
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                init_cnt <= '0;
    else if (state_q == INIT)  init_cnt <= init_cnt + 32'd1;
  end

  assign init_done = (state_q == RUN);

  assign push  = mem.memrequest_en && !busy && !q_full;
  assign q_din = '{addr: mem.memrequest_addr, we: mem.memrequest_write_enable,
                   wdata: mem.memrequest_write_data};
  assign pop   = !q_empty && !inject;

  memreq_queue #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (q_din),
    .pop   (pop),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign in_range = (q_dout.addr < DEPTH_A);
  assign mem_idx  = q_dout.addr[IDX_W-1:0];

  // Array is deliberately outside reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (q_dout.we && in_range) ram[mem_idx] <= q_dout.wdata;
      rd_raw <= ram[mem_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv         <= '0;
      p0_keep    <= 1'b0;
      for (int i = 1; i < READ_LATENCY; i++) pd[i] <= '0;
      complete_q <= 1'b0;
      resp_q     <= '0;
      oor_count  <= '0;
    end else begin
      pv      <= {pv[READ_LATENCY-2:0], pop};
      p0_keep <= pop && !q_dout.we && in_range;
      pd[1]   <= p0_keep ? rd_raw : '0;
      for (int i = 2; i < READ_LATENCY; i++) pd[i] <= pd[i-1];
      complete_q <= pv[READ_LATENCY-1];
      resp_q     <= pd[READ_LATENCY-1];
      if (pop && !in_range && oor_count != 16'hFFFF) oor_count <= oor_count + 16'd1;
    end
  end

  assign mem.memrequest_busy      = busy;
  assign mem.memrequest_complete  = complete_q;
  assign mem.memrequest_resp_data = resp_q;

endmodule

// File: tb/tb_memrequest_responder.sv
// tb/tb_memrequest_responder.sv - directed and table-driven bench for memrequest_responder
module tb_memrequest_responder;
  localparam int RL    = 4;
  localparam int DEPTH = 115200;
`ifdef MEMREQ_BUSY_INJECT_EN
  localparam bit FIXED_LAT = 1'b0;
`else
  localparam bit FIXED_LAT = 1'b1;
`endif

  typedef struct {
    logic [127:0] data;
    bit           chk_data;
    bit           chk_lat;
    int           acc;
  } exp_t;

  typedef struct {
    logic         we;
    logic [23:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic [15:0] oor_count;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int comp_cnt = 0;
  int stall_total = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [127:0] model [int];
  vec_t tbl [8];

  memrequest_responder_if #(.ADDR_W(24), .DATA_W(128)) bus ();

  memrequest_responder #(
    .ADDR_W(24), .DATA_W(128), .DEPTH(DEPTH), .QDEPTH(8), .READ_LATENCY(RL), .INIT_CYCLES(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (bus),
    .init_done (init_done),
    .oor_count (oor_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.memrequest_complete) begin
      comp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_complete", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_data) check("resp_data", bus.memrequest_resp_data, mon_e.data);
        if (mon_e.chk_lat)  check("latency", cyc - mon_e.acc, 1 + RL);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [23:0] a, input logic we, input logic [127:0] d,
                      input logic [127:0] e, input bit chk_data, input bit rec);
    int   waitc = 0;
    exp_t ent;
    bus.memrequest_addr         = a;
    bus.memrequest_write_enable = we;
    bus.memrequest_write_data   = d;
    bus.memrequest_en           = 1'b1;
    @(negedge clk);
    while (bus.memrequest_busy && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    stall_total += waitc;
    if (bus.memrequest_busy) begin
      check("accept_timeout", 1, 0);
      bus.memrequest_en = 1'b0;
      return;
    end
    ent.data     = e;
    ent.chk_data = chk_data;
    ent.chk_lat  = FIXED_LAT;
    ent.acc      = cyc + 1;
    if (rec) exp_q.push_back(ent);
    @(posedge clk);
    #1;
    bus.memrequest_en = 1'b0;
  endtask

  task automatic send_m(input logic [23:0] a, input logic we, input logic [127:0] d);
    logic [127:0] e = '0;
    bit           known = 1'b1;
    if (we) begin
      if (a < DEPTH) model[int'(a)] = d;
    end else if (a < DEPTH) begin
      if (model.exists(int'(a))) e = model[int'(a)];
      else known = 1'b0;
    end
    send(a, we, d, e, known, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Entered right after rst_n release at a negedge; a strobe is held during the hold.
  task automatic init_hold();
    int n = 0;
    bit early = 1'b0;
    bus.memrequest_addr         = 24'd9;
    bus.memrequest_write_enable = 1'b0;
    bus.memrequest_en           = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      if (!bus.memrequest_busy) break;
      n++;
      if (init_done) early = 1'b1;
      if (n == 10) bus.memrequest_en = 1'b0;
    end
    check("init_busy_cycles", n, 64);
    check("init_done_rise", init_done, 1);
    check("init_done_early", early, 0);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int snap;
    logic [23:0] a;

    tbl[0] = '{1'b1, 24'd5,      128'hDEADBEEF, 128'h0};
    tbl[1] = '{1'b0, 24'd5,      128'h0,        128'hDEADBEEF};
    tbl[2] = '{1'b1, 24'd0,      128'h1234,     128'h0};
    tbl[3] = '{1'b1, 24'd115200, 128'hBAD,      128'h0};
    tbl[4] = '{1'b0, 24'd115200, 128'h0,        128'h0};
    tbl[5] = '{1'b0, 24'd0,      128'h0,        128'h1234};
    tbl[6] = '{1'b1, 24'd115199, 128'hCAFE,     128'h0};
    tbl[7] = '{1'b0, 24'd115199, 128'h0,        128'hCAFE};

    rst_n = 1'b0;
    bus.memrequest_en           = 1'b0;
    bus.memrequest_addr         = '0;
    bus.memrequest_write_enable = 1'b0;
    bus.memrequest_write_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.memrequest_busy, 1);
    check("rst_complete", bus.memrequest_complete, 0);
    check("rst_resp_data", bus.memrequest_resp_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_oor_count", oor_count, 0);

    rst_n = 1'b1;
    init_hold();

    sync();
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we && tbl[i].addr < DEPTH) model[int'(tbl[i].addr)] = tbl[i].wdata;
      send(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].exp, 1'b1, 1'b1);
    end
    drain();
    check("oor_count", oor_count, 2);

    sync();
    stall_total = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        send_m(24'((i / 2) % 500), 1'b1, {$urandom, $urandom, $urandom, $urandom});
      end else begin
        a = (i % 4 == 1) ? 24'(((i - 1) / 2) % 500) : 24'(((i / 2) * 3) % 500);
        send_m(a, 1'b0, '0);
      end
    end
    drain();
`ifndef MEMREQ_BUSY_INJECT_EN
    check("stream_stalls", stall_total, 0);
`endif

    sync();
    send(24'd1, 1'b0, '0, '0, 1'b0, 1'b0);
    send(24'd2, 1'b0, '0, '0, 1'b0, 1'b0);
    send(24'd3, 1'b0, '0, '0, 1'b0, 1'b0);
    sync();
    snap  = comp_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_complete", bus.memrequest_complete, 0);
    check("midrst_busy", bus.memrequest_busy, 1);
    check("midrst_oor_count", oor_count, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_hold();
    repeat (20) @(negedge clk);
    check("midrst_no_complete", comp_cnt, snap);

    sync();
    send_m(24'd5, 1'b0, '0);
    send_m(24'd0, 1'b0, '0);
    drain();

`ifdef MEMREQ_BUSY_INJECT_EN
    sync();
    for (int i = 0; i < 10000; i++) begin
      repeat ($urandom_range(0, 1)) sync();
      send_m(24'($urandom_range(0, 499)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom, $urandom, $urandom});
    end
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
